// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game state machine: lives, score, hit window, optional hiscore.
// Optional feature macro: GAME_HISCORE_EN (keeps a best-score register across games).
module game_flow_ctrl #(
  parameter int LIVES     = 3,
  parameter int HIT_TICKS = 8,
  parameter int SCORE_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic               crash,
  output logic               det_rst_n,
  output logic               step_en,
  output logic               playing,
  output logic               flash,
  output logic               game_over,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [2:0]         lives_n;
  logic [SCORE_W-1:0] score_n, score_inc;
  logic [7:0]         hit_cnt, hit_n;
  logic               flash_n;

  assign score_inc = (&score) ? score : score + 1'b1;
  assign step_en   = tick & ((state == S_PLAY) || (state == S_HIT));

  always_comb begin
    state_n = state;
    lives_n = lives;
    score_n = score;
    hit_n   = hit_cnt;
    flash_n = flash;
    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_n = S_PLAY;
          lives_n = 3'(LIVES);
          score_n = '0;
          hit_n   = '0;
          flash_n = 1'b0;
        end
      end
      S_PLAY: begin
        // crash wins over a coincident tick; the score does not advance
        if (crash) begin
          if (lives > 3'd1) begin
            state_n = S_HIT;
            lives_n = lives - 3'd1;
            hit_n   = 8'(HIT_TICKS);
          end else begin
            state_n = S_OVER;
            lives_n = 3'd0;
          end
        end else if (tick) begin
          score_n = score_inc;
        end
      end
      S_HIT: begin
        if (tick) begin
          score_n = score_inc;
          if (hit_cnt <= 8'd1) begin
            state_n = S_PLAY;
            hit_n   = '0;
            flash_n = 1'b0;
          end else begin
            hit_n   = hit_cnt - 8'd1;
            flash_n = ~flash;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        lives_n = 3'd0;
        score_n = '0;
        hit_n   = '0;
        flash_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lives     <= 3'd0;
      score     <= '0;
      hit_cnt   <= '0;
      flash     <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      det_rst_n <= 1'b0;
    end else begin
      state     <= state_n;
      lives     <= lives_n;
      score     <= score_n;
      hit_cnt   <= hit_n;
      flash     <= flash_n;
      playing   <= (state_n == S_PLAY) || (state_n == S_HIT);
      game_over <= (state_n == S_OVER);
      det_rst_n <= (state_n == S_PLAY);
    end
  end

`ifdef GAME_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;

  // score is frozen on the entering crash, so the current value is final
  always_ff @(posedge clk) begin
    if (rst) begin
      hiscore_q <= '0;
    end else if ((state != S_OVER) && (state_n == S_OVER) && (score > hiscore_q)) begin
      hiscore_q <= score;
    end
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - scoreboard bench for game_flow_ctrl (directed vectors).
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, tick = 1'b0, crash = 1'b0;

  logic       det_rst_n, step_en, playing, flash, game_over;
  logic [2:0] lives;
  logic [9:0] score, hiscore;

  logic       det_rst_n4, step_en4, playing4, flash4, game_over4;
  logic [2:0] lives4;
  logic [3:0] score4, hiscore4;

`ifdef GAME_HISCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  game_flow_ctrl #(.LIVES(3), .HIT_TICKS(8), .SCORE_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .crash(crash),
    .det_rst_n(det_rst_n), .step_en(step_en), .playing(playing), .flash(flash),
    .game_over(game_over), .lives(lives), .score(score), .hiscore(hiscore)
  );

  game_flow_ctrl #(.LIVES(3), .HIT_TICKS(8), .SCORE_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .crash(crash),
    .det_rst_n(det_rst_n4), .step_en(step_en4), .playing(playing4), .flash(flash4),
    .game_over(game_over4), .lives(lives4), .score(score4), .hiscore(hiscore4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    string name;
    int    sel;
    int    exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic int get_sig(input int sel);
    case (sel)
      0: return int'(playing);
      1: return int'(flash);
      2: return int'(game_over);
      3: return int'(det_rst_n);
      4: return int'(lives);
      5: return int'(score);
      6: return int'(hiscore);
      7: return int'(step_en);
      8: return int'(score4);
      default: return -1;
    endcase
  endfunction

  // monitor: each expectation is tagged with the cycle it belongs to
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      int   got;
      e   = q.pop_front();
      got = get_sig(e.sel);
      n_cmp++;
      if (e.cyc != cyc || got != e.exp) begin
        n_fail++;
        $display("FAIL %s (sig %0d, cycle %0d): got %0d expected %0d",
                 e.name, e.sel, e.cyc, got, e.exp);
      end
    end
  end

  task automatic push(input string nm, input int sel, input int val);
    exp_t e;
    if (val < 0) return;
    e.cyc  = cyc;
    e.name = nm;
    e.sel  = sel;
    e.exp  = val;
    q.push_back(e);
  endtask

  task automatic drive(input logic s, input logic t, input logic c, input int se);
    start = s;
    tick  = t;
    crash = c;
    push("step_en", 7, se);
    @(posedge clk);
    #1;
    start = 1'b0;
    tick  = 1'b0;
    crash = 1'b0;
  endtask

  task automatic chk(input string nm, input int pl, input int fl, input int go,
                     input int det, input int lv, input int sc);
    push({nm, ".playing"},   0, pl);
    push({nm, ".flash"},     1, fl);
    push({nm, ".game_over"}, 2, go);
    push({nm, ".det_rst_n"}, 3, det);
    push({nm, ".lives"},     4, lv);
    push({nm, ".score"},     5, sc);
  endtask

  task automatic chk_hs(input string nm, input int v);
    push({nm, ".hiscore"}, 6, HS_EN ? v : 0);
  endtask

  task automatic hit_window();
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset", 0, 0, 0, 0, 0, 0);
    chk_hs("reset", 0);

    drive(1'b1, 1'b0, 1'b0, 0);
    chk("start", 1, 0, 0, 1, 3, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1);
      chk("tick", 1, -1, 0, 1, 3, i);
    end
    push("score4_5", 8, 5);

    drive(1'b1, 1'b1, 1'b0, 1);
    chk("start_in_play", 1, 0, 0, 1, 3, 6);

    drive(1'b0, 1'b1, 1'b1, 1);
    chk("crash_tick", 1, 0, 0, 0, 2, 6);

    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        drive(1'b0, 1'b0, 1'b1, 0);
        chk("hit_crash", 1, -1, 0, 0, 2, 6 + i);
      end
      drive(1'b0, 1'b1, 1'b0, 1);
      chk("hit_tick", 1, (i == 7) ? 0 : ((i % 2 == 0) ? 1 : 0), 0,
          (i == 7) ? 1 : 0, 2, 7 + i);
    end

    drive(1'b0, 1'b0, 1'b1, 0);
    chk("crash2", 1, 0, 0, 0, 1, 14);
    hit_window();
    chk("win2", 1, 0, 0, 1, 1, 22);
    drive(1'b0, 1'b0, 1'b1, 0);
    chk("over", 0, 0, 1, 0, 0, 22);
    chk_hs("over", 22);
    drive(1'b0, 1'b1, 1'b0, 0);
    chk("over_tick", 0, 0, 1, 0, 0, 22);
    drive(1'b0, 1'b0, 1'b1, 0);
    chk("over_crash", 0, 0, 1, 0, 0, 22);

    drive(1'b1, 1'b0, 1'b0, 0);
    chk("restart", 1, 0, 0, 1, 3, 0);
    chk_hs("restart", 22);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b1, 0);
    chk("crash3", 1, 0, 0, 0, 2, 3);
    drive(1'b0, 1'b1, 1'b0, 1);
    chk("hit_flash", 1, 1, 0, 0, 2, 4);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1);
    rst = 1'b0;
    chk("rst_hit", 0, 0, 0, 0, 0, 0);
    chk_hs("rst_hit", 0);

    drive(1'b1, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1);
      if (i == 15 || i == 16 || i == 20) push("score4_sat", 8, 15);
    end
    chk("sat_game", 1, 0, 0, 1, 3, 20);
    drive(1'b0, 1'b0, 1'b1, 0);
    hit_window();
    drive(1'b0, 1'b0, 1'b1, 0);
    hit_window();
    chk("sat_win", 1, 0, 0, 1, 1, 36);
    drive(1'b0, 1'b0, 1'b1, 0);
    chk("over36", 0, 0, 1, 0, 0, 36);
    chk_hs("over36", 36);

    drive(1'b1, 1'b0, 1'b0, 0);
    chk_hs("restart36", 36);
    drive(1'b0, 1'b0, 1'b1, 0);
    hit_window();
    drive(1'b0, 1'b0, 1'b1, 0);
    hit_window();
    drive(1'b0, 1'b0, 1'b1, 0);
    chk("over16", 0, 0, 1, 0, 0, 16);
    chk_hs("over16", 36);

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 3, meaning lives loaded at game start (legal range 1..7).
REQ-002 SHALL have parameter HIT_TICKS, default 8, meaning invulnerability length in tick pulses (legal range 1..255).
REQ-003 SHALL have parameter SCORE_W, default 10, meaning score/hiscore width in bits.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle start/restart pulse, debounced upstream.
REQ-007 SHALL have port tick  input  1  one-cycle game-step pulse.
REQ-008 SHALL have port crash  input  1  one-cycle crash pulse from the crash detector.
REQ-009 SHALL have port det_rst_n  output  1  active-low reset driven to the crash detector.
REQ-010 SHALL have port step_en  output  1  gated tick to the obstacle generator.
REQ-011 SHALL have port playing  output  1  high in PLAY or HIT.
REQ-012 SHALL have port flash  output  1  player blink during HIT.
REQ-013 SHALL have port game_over  output  1  high in OVER.
REQ-014 SHALL have port lives  output  3  remaining lives.
REQ-015 SHALL have port score  output  SCORE_W  current score.
REQ-016 SHALL have port hiscore  output  SCORE_W  best score (see Configuration).

Function
REQ-017 SHALL implement states IDLE, PLAY, HIT, OVER; all outputs registered except step_en; registered outputs update one clk after the causing input.
REQ-018 SHALL leave IDLE or OVER on start, entering PLAY with lives=LIVES, score=0, hit counter=0; crash and tick are ignored in IDLE and OVER.
REQ-019 SHALL, in PLAY on crash with lives>1, decrement lives, load hit counter with HIT_TICKS, and enter HIT.
REQ-020 SHALL, in PLAY on crash with lives==1, set lives=0 and enter OVER.
REQ-021 SHALL, in PLAY and HIT, increment score by 1 per tick, saturating at all-ones (no wrap).
REQ-022 SHALL give crash priority over tick in the same cycle in PLAY: the state change is taken and score is not incremented.
REQ-023 SHALL, in HIT, ignore crash, decrement the hit counter on each tick, and toggle flash on each tick; the tick that brings the counter to 0 returns the block to PLAY with flash=0.
REQ-024 SHALL ignore start while in PLAY or HIT.
REQ-025 SHALL drive det_rst_n=1 only in PLAY; det_rst_n=0 in IDLE, HIT, and OVER, so the detector is re-armed after each hit.
REQ-026 SHALL drive step_en = tick AND (state is PLAY or HIT), combinationally.
REQ-027 SHALL hold score and lives frozen in OVER until the next start.
REQ-028 SHALL force an illegal state encoding to IDLE on the next clk.

Reset
REQ-029 SHALL, on rst=1 at posedge clk, enter IDLE with lives=0, score=0, hiscore=0, flash=0, game_over=0, playing=0, det_rst_n=0, and hit counter=0.
REQ-030 SHALL give rst priority over every other input, including mid-HIT and mid-PLAY.

Configuration
REQ-031 SHALL, with GAME_HISCORE_EN defined, load hiscore with score on the cycle OVER is entered, when score > hiscore; hiscore survives start and is cleared only by rst.
REQ-032 SHALL, without GAME_HISCORE_EN, tie hiscore to 0 and contain no hiscore register; all other behaviour is identical.

Verification
REQ-033 SHALL pass this test: rst, then start, then 5 ticks -> playing=1, score=5, lives=3, det_rst_n=1, step_en pulses 5 times.
REQ-034 SHALL pass this test: in PLAY, crash and tick in the same cycle -> next cycle state HIT, lives=2, score unchanged, det_rst_n=0.
REQ-035 SHALL pass this test: in HIT with HIT_TICKS=8, 3 crash pulses plus 8 ticks -> lives stays 2, flash toggles 8 times, return to PLAY after the 8th tick.
REQ-036 SHALL pass this test: three crashes separated by full HIT windows -> lives 3,2,1,0; game_over=1; further ticks leave score frozen and step_en=0.
REQ-037 SHALL pass this test: with GAME_HISCORE_EN, game 1 ends at score=12, game 2 ends at score=7 -> hiscore=12; without the macro, hiscore=0 throughout.
REQ-038 SHALL pass this test: SCORE_W=4 with 20 ticks in PLAY -> score saturates at 15; rst asserted mid-HIT -> IDLE with all reset values next cycle.
